hub75_scan_ctrl: RTL and testbench

Scan sequencer for the HUB75 frame buffer. It walks the buffer row pair by row pair and bit plane by bit plane, using one read per pixel. It shifts RGB bits into the panel, latches each row and gates OE with binary-coded display times. It consumes the control word and pixels-per-row setting from the APB register block, and owns the read port of the 32-bit frame buffer (address {row[5:0], col[8:0]}).

---
 rtl/hub75_scan_ctrl_if.sv | 20 ++
 rtl/hub75_scan_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_hub75_scan_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hub75_scan_ctrl_if.sv
// Frame-buffer read port between the HUB75 scan sequencer and the pixel RAM.
// The sequencer is the master; the RAM returns mem_rdata one cycle after a
// strobed address.
interface hub75_scan_ctrl_if;
    logic        mem_rd;
    logic [14:0] mem_raddr;
    logic [31:0] mem_rdata;

    modport master (
        output mem_rd,
        output mem_raddr,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd,
        input  mem_raddr,
        output mem_rdata
    );
endinterface

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan sequencer: walks row pairs and bit planes, fetching one upper and
// one lower pixel per column, shifting them into the panel, latching the row
// and gating OE for a binary-weighted display time per plane.
module hub75_scan_ctrl #(
    parameter int ROWS    = 32,
    parameter int ADDR_W  = 4,
    parameter int PLANES  = 4,
    parameter int BASE_OE = 8
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic [31:0]       control,
    input  logic [8:0]        pixels_per_row,
    hub75_scan_ctrl_if.master fb,
    output logic              hub_r0,
    output logic              hub_g0,
    output logic              hub_b0,
    output logic              hub_r1,
    output logic              hub_g1,
    output logic              hub_b1,
    output logic              hub_clk,
    output logic              hub_lat,
    output logic              hub_oe_n,
    output logic [ADDR_W-1:0] hub_addr,
    output logic              frame_done
);

    localparam int HALF   = ROWS / 2;
    localparam int PL_W   = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int OE_MAX = BASE_OE << (PLANES - 1);
    localparam int OE_W   = $clog2(OE_MAX + 1);
    localparam logic [2:0] BIT_BASE = 3'(8 - PLANES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_U,
        S_FETCH_L,
        S_SETUP,
        S_CLK_LO,
        S_CLK_HI,
        S_LATCH,
        S_DISPLAY
    } state_t;

    state_t            state_reg, state_next;
    logic [8:0]        col_reg, col_next;
    logic [8:0]        ppr_lat_reg, ppr_lat_next;
    logic [ADDR_W-1:0] row_reg, row_next;
    logic [PL_W-1:0]   plane_reg, plane_next;
    logic [OE_W-1:0]   oe_cnt_reg, oe_cnt_next;
    logic              frame_done_next;

    logic              mem_rd_reg;
    logic [14:0]       mem_raddr_reg;
    logic [2:0]        rgb_u_reg, rgb_l_reg;
    logic              hub_clk_reg, hub_lat_reg, hub_oe_n_reg, frame_done_reg;
    logic [ADDR_W-1:0] hub_addr_reg;

    logic [8:0]        ppr_eff;
    logic [OE_W-1:0]   oe_len;
    logic [2:0]        bit_sel;
    logic [2:0]        plane_bit;
    logic [5:0]        row_u, row_l;
    logic              unused_ctrl;

    // Only the enable and blank bits of the control word matter here.
    assign unused_ctrl = ^control[31:2];

    // A zero column count would never reach the latch; run one column instead.
    assign ppr_eff = (pixels_per_row == 9'd0) ? 9'd1 : pixels_per_row;
    assign oe_len  = OE_W'(BASE_OE) << plane_reg;
    assign bit_sel = BIT_BASE + 3'(plane_reg);
    assign row_u   = 6'(row_next);
    assign row_l   = 6'(row_next) + 6'(HALF);

    // Pick the current plane's bit out of each colour byte (index 2 = R, 0 = B).
    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_chan
        logic [7:0] chan_byte;
        assign chan_byte     = fb.mem_rdata[8*gi +: 8];
        assign plane_bit[gi] = chan_byte[bit_sel];
    end

    // State and scan counters.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_reg   <= S_IDLE;
            col_reg     <= '0;
            ppr_lat_reg <= 9'd1;
            row_reg     <= '0;
            plane_reg   <= '0;
            oe_cnt_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            col_reg     <= col_next;
            ppr_lat_reg <= ppr_lat_next;
            row_reg     <= row_next;
            plane_reg   <= plane_next;
            oe_cnt_reg  <= oe_cnt_next;
        end
    end

    // Next-state and counter logic for the column/latch/display sequence.
    always_comb begin
        state_next      = state_reg;
        col_next        = col_reg;
        ppr_lat_next    = ppr_lat_reg;
        row_next        = row_reg;
        plane_next      = plane_reg;
        oe_cnt_next     = oe_cnt_reg;
        frame_done_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (control[0]) begin
                    state_next   = S_FETCH_U;
                    col_next     = '0;
                    ppr_lat_next = ppr_eff;
                end
            end
            S_FETCH_U: state_next = S_FETCH_L;
            S_FETCH_L: state_next = S_SETUP;
            S_SETUP:   state_next = S_CLK_LO;
            S_CLK_LO:  state_next = S_CLK_HI;
            S_CLK_HI: begin
                if (col_reg == ppr_lat_reg - 9'd1) begin
                    state_next = S_LATCH;
                end else begin
                    col_next   = col_reg + 9'd1;
                    state_next = S_FETCH_U;
                end
            end
            S_LATCH: begin
                col_next    = '0;
                oe_cnt_next = oe_len - OE_W'(1);
                state_next  = S_DISPLAY;
            end
            S_DISPLAY: begin
                if (oe_cnt_reg == '0) begin
                    if (plane_reg == PL_W'(PLANES - 1)) begin
                        plane_next = '0;
                        if (row_reg == ADDR_W'(HALF - 1)) begin
                            row_next        = '0;
                            frame_done_next = 1'b1;
                        end else begin
                            row_next = row_reg + ADDR_W'(1);
                        end
                    end else begin
                        plane_next = plane_reg + PL_W'(1);
                    end
                    if (control[0]) begin
                        state_next   = S_FETCH_U;
                        col_next     = '0;
                        ppr_lat_next = ppr_eff;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    oe_cnt_next = oe_cnt_reg - OE_W'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Registered outputs, decoded from the state being entered so they line
    // up with that state's cycle.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            mem_rd_reg     <= 1'b0;
            mem_raddr_reg  <= '0;
            rgb_u_reg      <= '0;
            rgb_l_reg      <= '0;
            hub_clk_reg    <= 1'b0;
            hub_lat_reg    <= 1'b0;
            hub_oe_n_reg   <= 1'b1;
            hub_addr_reg   <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            mem_rd_reg     <= (state_next == S_FETCH_U) || (state_next == S_FETCH_L);
            case (state_next)
                S_FETCH_U: mem_raddr_reg <= {row_u, col_next};
                S_FETCH_L: mem_raddr_reg <= {row_l, col_next};
                default:   mem_raddr_reg <= '0;
            endcase
            hub_clk_reg    <= (state_next == S_CLK_HI);
            hub_lat_reg    <= (state_next == S_LATCH);
            hub_oe_n_reg   <= !((state_next == S_DISPLAY) && !control[1]);
            frame_done_reg <= frame_done_next;
            if (state_next == S_LATCH) begin
                hub_addr_reg <= row_next;
            end
            if (state_next == S_IDLE) begin
                rgb_u_reg <= '0;
                rgb_l_reg <= '0;
            end else begin
                if (state_reg == S_FETCH_L) begin
                    rgb_u_reg <= plane_bit;
                end
                if (state_reg == S_SETUP) begin
                    rgb_l_reg <= plane_bit;
                end
            end
        end
    end

    assign fb.mem_rd    = mem_rd_reg;
    assign fb.mem_raddr = mem_raddr_reg;
    assign {hub_r0, hub_g0, hub_b0} = rgb_u_reg;
    assign {hub_r1, hub_g1, hub_b1} = rgb_l_reg;
    assign hub_clk    = hub_clk_reg;
    assign hub_lat    = hub_lat_reg;
    assign hub_oe_n   = hub_oe_n_reg;
    assign hub_addr   = hub_addr_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: single row-plane vectors from a table, then
// full-frame, stop/resume and mid-display reset sequences.
module tb_hub75_scan_ctrl;

    logic        pclk = 1'b0;
    logic        preset;
    logic [31:0] control;
    logic [8:0]  pixels_per_row;
    logic        hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1;
    logic        hub_clk, hub_lat, hub_oe_n, frame_done;
    logic [3:0]  hub_addr;
    logic [31:0] rdata_q;
    logic [31:0] mem [0:32767];

    hub75_scan_ctrl_if fb ();

    hub75_scan_ctrl dut (
        .pclk           (pclk),
        .preset         (preset),
        .control        (control),
        .pixels_per_row (pixels_per_row),
        .fb             (fb),
        .hub_r0         (hub_r0),
        .hub_g0         (hub_g0),
        .hub_b0         (hub_b0),
        .hub_r1         (hub_r1),
        .hub_g1         (hub_g1),
        .hub_b1         (hub_b1),
        .hub_clk        (hub_clk),
        .hub_lat        (hub_lat),
        .hub_oe_n       (hub_oe_n),
        .hub_addr       (hub_addr),
        .frame_done     (frame_done)
    );

    always #5 pclk = ~pclk;

    // Frame buffer with one-cycle read latency.
    always @(posedge pclk) begin
        if (fb.mem_rd) rdata_q <= mem[fb.mem_raddr];
    end
    assign fb.mem_rdata = rdata_q;

    typedef struct {
        logic [31:0] ctrl;
        logic [8:0]  ppr;
        logic [31:0] up;
        logic [31:0] lo;
        int          rises;
        int          lat;
        int          oe;
        logic [5:0]  bits;
    } vec_t;

    vec_t vecs [7];

    int n_chk = 0;
    int n_fail = 0;
    int rel, n_rise, first_rise, n_lat, lat_rel, n_oe, n_fd, fd_rel, n_rd;
    int n_overlap = 0;
    logic prev_clk = 1'b0;
    int         oe_log   [80];
    logic [3:0] lat_addr [80];
    logic [5:0] lat_bits [80];
    logic [14:0] rd_log  [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fill(input logic [31:0] up, input logic [31:0] lo);
        for (int i = 0; i < 32768; i++) mem[i] = ((i >> 9) < 16) ? up : lo;
    endtask

    task automatic clr_stats();
        rel = -1; n_rise = 0; first_rise = -1; n_lat = 0; lat_rel = -1;
        n_oe = 0; n_fd = 0; fd_rel = -1; n_rd = 0;
    endtask

    // Advance one cycle and record what the panel side shows in it.
    task automatic step();
        @(posedge pclk);
        #1;
        rel++;
        if (hub_clk && !prev_clk) begin
            if (n_rise == 0) first_rise = rel;
            n_rise++;
        end
        prev_clk = hub_clk;
        if (hub_lat) begin
            if (n_lat < 80) begin
                lat_addr[n_lat] = hub_addr;
                lat_bits[n_lat] = {hub_r0, hub_g0, hub_b0, hub_r1, hub_g1, hub_b1};
                oe_log[n_lat]   = 0;
            end
            lat_rel = rel;
            n_lat++;
        end
        if (!hub_oe_n) begin
            n_oe++;
            if (n_lat > 0 && n_lat <= 80) oe_log[n_lat-1]++;
        end
        if (frame_done) begin
            n_fd++;
            fd_rel = rel;
        end
        if (fb.mem_rd) begin
            if (n_rd < 8) rd_log[n_rd] = fb.mem_raddr;
            n_rd++;
        end
        if (!hub_oe_n && (hub_clk || hub_lat || fb.mem_rd)) n_overlap++;
    endtask

    task automatic do_reset();
        preset = 1'b1;
        step();
        step();
        preset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h1,  9'd64, 32'h00F0F0F0, 32'h00F0F0F0, 64, 320, 8, 6'b111111};
        vecs[1] = '{32'h1,  9'd2,  32'h00FF0000, 32'h000000FF, 2,  10,  8, 6'b100001};
        vecs[2] = '{32'h3,  9'd2,  32'h00F0F0F0, 32'h00F0F0F0, 2,  10,  0, 6'b111111};
        vecs[3] = '{32'h1,  9'd0,  32'h000F0F0F, 32'h000F0F0F, 1,  5,   8, 6'b000000};
        vecs[4] = '{32'h3,  9'd0,  32'h00F0F0F0, 32'h00F0F0F0, 1,  5,   0, 6'b111111};
        vecs[5] = '{32'h1,  9'd1,  32'h0000FF00, 32'h00FF00FF, 1,  5,   8, 6'b010101};
        vecs[6] = '{32'h1,  9'd3,  32'h00101010, 32'h00000000, 3,  15,  8, 6'b111000};

        preset = 1'b1;
        control = '0;
        pixels_per_row = 9'd0;
        fill(32'h0, 32'h0);
        clr_stats();
        repeat (2) @(posedge pclk);
        #1;
        chk("reset_outputs", 32'({fb.mem_rd, fb.mem_raddr, hub_r0, hub_g0, hub_b0, hub_r1, hub_g1,
             hub_b1, hub_clk, hub_lat, hub_oe_n, hub_addr, frame_done}), 32'h20);
        preset = 1'b0;
        repeat (6) step();
        chk("idle_hold", 32'({fb.mem_rd, hub_clk, hub_lat, hub_oe_n}), 32'h1);

        // Table: one row-plane from reset, then stop.
        for (int v = 0; v < 7; v++) begin
            fill(vecs[v].up, vecs[v].lo);
            pixels_per_row = vecs[v].ppr;
            control = '0;
            do_reset();
            clr_stats();
            control = vecs[v].ctrl;
            step();
            control = vecs[v].ctrl & 32'hFFFF_FFFE;
            repeat (5 * vecs[v].rises + 20) step();
            $display("vec %0d ctrl=%0h ppr=%0d rises=%0d lat@%0d oe=%0d bits=%b",
                     v, vecs[v].ctrl, vecs[v].ppr, n_rise, lat_rel, n_oe, lat_bits[0]);
            chk($sformatf("v%0d_first_rise", v), first_rise, 4);
            chk($sformatf("v%0d_rises", v), n_rise, vecs[v].rises);
            chk($sformatf("v%0d_latches", v), n_lat, 1);
            chk($sformatf("v%0d_lat_cycle", v), lat_rel, vecs[v].lat);
            chk($sformatf("v%0d_oe_width", v), oe_log[0], vecs[v].oe);
            chk($sformatf("v%0d_bits", v), 32'(lat_bits[0]), 32'(vecs[v].bits));
            chk($sformatf("v%0d_reads", v), n_rd, 2 * vecs[v].rises);
            chk($sformatf("v%0d_addr0", v), 32'(rd_log[0]), 32'h0000);
            chk($sformatf("v%0d_addr1", v), 32'(rd_log[1]), 32'h2000);
            if (v == 1) begin
                chk("v1_addr2", 32'(rd_log[2]), 32'h0001);
                chk("v1_addr3", 32'(rd_log[3]), 32'h2001);
            end
            chk($sformatf("v%0d_idle_oe_n", v), hub_oe_n, 1);
        end

        // Full frame, ppr=1, plane-dependent bit selection.
        fill(32'h00500000, 32'h000000A0);
        pixels_per_row = 9'd1;
        control = '0;
        do_reset();
        clr_stats();
        control = 32'h1;
        while (n_fd == 0 && rel < 3000) step();
        $display("frame: frame_done@%0d latches=%0d", fd_rel, n_lat);
        chk("frame_done_cycle", fd_rel, 2304);
        chk("frame_latches", n_lat, 64);
        step();
        chk("frame_done_width", frame_done, 0);
        control = '0;
        repeat (30) step();
        chk("frame_done_count", n_fd, 1);
        for (int k = 0; k < 64; k++) begin
            chk($sformatf("frame_addr_%0d", k), 32'(lat_addr[k]), k / 4);
            chk($sformatf("frame_oe_%0d", k), oe_log[k], 8 << (k % 4));
            chk($sformatf("frame_bits_%0d", k), 32'(lat_bits[k]), (k % 2 == 0) ? 32'h20 : 32'h01);
        end

        // Clear enable while shifting row 3 plane 1, then resume.
        fill(32'h00F0F0F0, 32'h00F0F0F0);
        pixels_per_row = 9'd4;
        control = '0;
        do_reset();
        clr_stats();
        control = 32'h1;
        while (n_lat < 13 && rel < 5000) step();
        while (!fb.mem_rd && rel < 5000) step();
        repeat (3) step();
        control = '0;
        repeat (150) step();
        $display("stop: latches=%0d row=%0d oe=%0d", n_lat, lat_addr[13], oe_log[13]);
        chk("stop_latches", n_lat, 14);
        chk("stop_row", 32'(lat_addr[13]), 3);
        chk("stop_oe", oe_log[13], 16);
        chk("stop_idle", 32'({hub_oe_n, fb.mem_rd}), 32'h2);
        control = 32'h1;
        repeat (60) step();
        control = '0;
        $display("resume: latches=%0d row=%0d oe=%0d", n_lat, lat_addr[14], oe_log[14]);
        chk("resume_latches", n_lat, 15);
        chk("resume_row", 32'(lat_addr[14]), 3);
        chk("resume_oe", oe_log[14], 32);

        // Reset asserted mid-display.
        pixels_per_row = 9'd2;
        do_reset();
        clr_stats();
        control = 32'h1;
        while (!(n_lat >= 5 && !hub_oe_n) && rel < 3000) step();
        chk("reach_display", 32'(n_lat >= 5 && !hub_oe_n), 1);
        chk("pre_reset_row", 32'(hub_addr), 1);
        #2;
        preset = 1'b1;
        #1;
        chk("reset_mid_display", 32'({hub_oe_n, hub_lat, fb.mem_rd, hub_clk, hub_addr}), 32'h80);
        #1;
        preset = 1'b0;
        clr_stats();
        repeat (25) step();
        $display("restart: lat@%0d row=%0d oe=%0d", lat_rel, lat_addr[0], oe_log[0]);
        chk("restart_lat_cycle", lat_rel, 10);
        chk("restart_row", 32'(lat_addr[0]), 0);
        chk("restart_oe", oe_log[0], 8);

        chk("no_shift_during_display", n_overlap, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
